sram_arbiter: RTL and testbench

- Owns the 32-bit asynchronous SRAM and shares it between three requesters: video refresh (VID), the RISC5 core (CPU) and a block-transfer DMA port (SPI/network buffers).
- Sequences each access as a fixed multi-cycle pattern on the shared clock.
- Generates all SRAM strobes, lane selects and data-bus direction.
- Replaces the ad-hoc stall/strobe glue at top level; the CPU stalls on its own handshake.

---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/sram_lane.sv | 35 +++
 rtl/sram_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the three-port asynchronous SRAM arbiter.
package sram_arb_pkg;

    localparam int AW_DEF          = 18;
    localparam int ACC_CYC_DEF     = 3;
    localparam int WE_START_DEF    = 1;
    localparam int WE_LEN_DEF      = 1;
    localparam int CPU_RUN_MAX_DEF = 4;

    typedef enum logic [1:0] {
        PORT_VID = 2'd0,
        PORT_CPU = 2'd1,
        PORT_DMA = 2'd2
    } port_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

endpackage

// File: rtl/sram_lane.sv
// Byte-lane decode for one SRAM word: lane enables, write-data replication
// and read-byte extraction. VID/DMA always present byte_i = 0.
module sram_lane (
    input  logic        byte_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] din_i,
    output logic [3:0]  be_n_o,
    output logic [31:0] dout_o,
    output logic [31:0] rdata_o
);

    logic [7:0] rd_byte;

    always_comb begin
        case (lane_i)
            2'd0:    rd_byte = din_i[7:0];
            2'd1:    rd_byte = din_i[15:8];
            2'd2:    rd_byte = din_i[23:16];
            default: rd_byte = din_i[31:24];
        endcase
    end

    always_comb begin
        be_n_o  = 4'h0;
        dout_o  = wdata_i;
        rdata_o = din_i;
        if (byte_i) begin
            be_n_o  = ~(4'b0001 << lane_i);
            dout_o  = {4{wdata_i[7:0]}};
            rdata_o = {24'h0, rd_byte};
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 32-bit SRAM between video, CPU and DMA requesters,
// running every access as a fixed ACC_CYC-cycle strobe pattern plus one idle cycle.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int ACC_CYC     = ACC_CYC_DEF,
    parameter int WE_START    = WE_START_DEF,
    parameter int WE_LEN      = WE_LEN_DEF,
    parameter int CPU_RUN_MAX = CPU_RUN_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_adr,
    output logic          vid_ack,
    output logic [31:0]   vid_rdata,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic          cpu_byte,
    input  logic [AW+1:0] cpu_adr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic [31:0]   cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_wr,
    input  logic [AW-1:0] dma_adr,
    input  logic [31:0]   dma_wdata,
    output logic          dma_ack,
    output logic [31:0]   dma_rdata,
    output logic [AW-1:0] sr_adr,
    output logic          sr_ce_n,
    output logic          sr_oe_n,
    output logic          sr_we_n,
    output logic [3:0]    sr_be_n,
    output logic [31:0]   sr_dout,
    output logic          sr_dout_en,
    input  logic [31:0]   sr_din
);

    localparam int KW = $clog2(ACC_CYC);
    localparam int RW = $clog2(CPU_RUN_MAX + 1);
    localparam logic [KW-1:0] K_LAST  = KW'(ACC_CYC - 1);
    localparam logic [KW-1:0] WE_LO   = KW'(WE_START);
    localparam logic [KW-1:0] WE_HI   = KW'(WE_START + WE_LEN);
    localparam logic [RW-1:0] RUN_MAX = RW'(CPU_RUN_MAX);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    port_e         port_q, port_d;
    logic [AW-1:0] adr_q, adr_d;
    logic          wr_q, wr_d;
    logic          byte_q, byte_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [RW-1:0] run_q, run_d;
    logic          vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
    logic [31:0]   vid_rdata_q, vid_rdata_d, cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;

    logic          gnt_vld;
    port_e         gnt_port;
    logic [3:0]    lane_be_n;
    logic [31:0]   lane_dout, lane_rdata;

    sram_lane u_lane (
        .byte_i  (byte_q),
        .lane_i  (lane_q),
        .wdata_i (wdata_q),
        .din_i   (sr_din),
        .be_n_o  (lane_be_n),
        .dout_o  (lane_dout),
        .rdata_o (lane_rdata)
    );

    // A port acked this cycle is still holding its old request; ignore it once.
    logic vid_ok, cpu_ok, dma_ok;
    assign vid_ok = vid_req & ~vid_ack_q;
    assign cpu_ok = cpu_req & ~cpu_ack_q;
    assign dma_ok = dma_req & ~dma_ack_q;

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_port = PORT_VID;
        if (state_q == ST_IDLE) begin
            if (vid_ok) begin
                gnt_vld  = 1'b1;
                gnt_port = PORT_VID;
            end else if (dma_ok && run_q == RUN_MAX) begin
                gnt_vld  = 1'b1;
                gnt_port = PORT_DMA;
            end else if (cpu_ok) begin
                gnt_vld  = 1'b1;
                gnt_port = PORT_CPU;
            end else if (dma_ok) begin
                gnt_vld  = 1'b1;
                gnt_port = PORT_DMA;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        port_d      = port_q;
        adr_d       = adr_q;
        wr_d        = wr_q;
        byte_d      = byte_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        vid_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        vid_rdata_d = vid_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d = ST_ACCESS;
                    k_d     = '0;
                    port_d  = gnt_port;
                    case (gnt_port)
                        PORT_CPU: begin
                            adr_d   = cpu_adr[AW+1:2];
                            wr_d    = cpu_wr;
                            byte_d  = cpu_byte;
                            lane_d  = cpu_adr[1:0];
                            wdata_d = cpu_wdata;
                        end
                        PORT_DMA: begin
                            adr_d   = dma_adr;
                            wr_d    = dma_wr;
                            byte_d  = 1'b0;
                            lane_d  = 2'd0;
                            wdata_d = dma_wdata;
                        end
                        default: begin
                            adr_d   = vid_adr;
                            wr_d    = 1'b0;
                            byte_d  = 1'b0;
                            lane_d  = 2'd0;
                            wdata_d = '0;
                        end
                    endcase
                end
            end
            ST_ACCESS: begin
                if (k_q == K_LAST) begin
                    state_d = ST_IDLE;
                    k_d     = '0;
                    case (port_q)
                        PORT_CPU: begin
                            cpu_ack_d   = 1'b1;
                            cpu_rdata_d = lane_rdata;
                        end
                        PORT_DMA: begin
                            dma_ack_d   = 1'b1;
                            dma_rdata_d = lane_rdata;
                        end
                        default: begin
                            vid_ack_d   = 1'b1;
                            vid_rdata_d = lane_rdata;
                        end
                    endcase
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bounds how many CPU accesses may overtake a waiting DMA request.
    always_comb begin
        run_d = run_q;
        if (!dma_req)
            run_d = '0;
        else if (gnt_vld && gnt_port == PORT_DMA)
            run_d = '0;
        else if (gnt_vld && gnt_port == PORT_CPU && run_q != RUN_MAX)
            run_d = run_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            port_q      <= PORT_VID;
            adr_q       <= '0;
            wr_q        <= 1'b0;
            byte_q      <= 1'b0;
            lane_q      <= 2'd0;
            wdata_q     <= '0;
            run_q       <= '0;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            vid_rdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            port_q      <= port_d;
            adr_q       <= adr_d;
            wr_q        <= wr_d;
            byte_q      <= byte_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            run_q       <= run_d;
            vid_ack_q   <= vid_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    logic in_acc, we_win;
    assign in_acc = (state_q == ST_ACCESS);
    assign we_win = (k_q >= WE_LO) && (k_q < WE_HI);

    assign sr_adr     = adr_q;
    assign sr_ce_n    = ~in_acc;
    assign sr_oe_n    = ~(in_acc & ~wr_q);
    assign sr_we_n    = ~(in_acc & wr_q & we_win);
    assign sr_be_n    = in_acc ? lane_be_n : 4'hF;
    assign sr_dout    = lane_dout;
    assign sr_dout_en = in_acc & wr_q;

    assign vid_ack   = vid_ack_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign vid_rdata = vid_rdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed CPU vector table, reset/priority sequences,
// then randomized three-port traffic against a transaction-level model.
module tb_sram_arbiter;

    localparam int AW   = 18;
    localparam int ACC  = 3;
    localparam int RMAX = 4;
    localparam int NC   = 900;
    localparam int HOLD = 300;

    logic          clk = 1'b0;
    logic          rst;
    logic          vid_req, vid_ack, cpu_req, cpu_wr, cpu_byte, cpu_ack, dma_req, dma_wr, dma_ack;
    logic [AW-1:0] vid_adr, dma_adr, sr_adr;
    logic [AW+1:0] cpu_adr;
    logic [31:0]   vid_rdata, cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, sr_dout, sr_din;
    logic          sr_ce_n, sr_oe_n, sr_we_n, sr_dout_en;
    logic [3:0]    sr_be_n;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_adr(vid_adr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_byte(cpu_byte), .cpu_adr(cpu_adr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .sr_adr(sr_adr), .sr_ce_n(sr_ce_n), .sr_oe_n(sr_oe_n), .sr_we_n(sr_we_n),
        .sr_be_n(sr_be_n), .sr_dout(sr_dout), .sr_dout_en(sr_dout_en), .sr_din(sr_din)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: reads while ce/oe low, lane writes while ce/we low and driven.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h01010101;
        end else if (!sr_ce_n && !sr_we_n && sr_dout_en) begin
            for (int b = 0; b < 4; b++)
                if (!sr_be_n[b]) mem[sr_adr[5:0]][8*b +: 8] <= sr_dout[8*b +: 8];
        end
    end
    assign sr_din = (!sr_ce_n && !sr_oe_n) ? mem[sr_adr[5:0]] : 32'hBAD0BAD0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic        byt;
        logic [19:0] adr;
        logic [31:0] wd;
        logic [17:0] eadr;
        logic [3:0]  ebe;
        logic [31:0] edata;   // sr_dout for writes, cpu_rdata for reads
    } vec_t;
    vec_t vt[11];

    // Observations from one CPU access
    int          t_lat, t_k, t_oe, t_en;
    logic        t_acked, t_stable;
    logic [7:0]  t_we;
    logic [17:0] t_adr;
    logic [3:0]  t_be;
    logic [31:0] t_dout, t_rd;

    task automatic cpu_op(input logic wr, input logic byt, input logic [19:0] adr, input logic [31:0] wd);
        cpu_req = 1'b1; cpu_wr = wr; cpu_byte = byt; cpu_adr = adr; cpu_wdata = wd;
        t_lat = 0; t_k = 0; t_oe = 0; t_en = 0; t_we = '0; t_acked = 1'b0; t_stable = 1'b1;
        t_adr = '0; t_be = '0; t_dout = '0; t_rd = '0;
        for (int n = 1; n <= 20 && !t_acked; n++) begin
            @(negedge clk);
            if (!sr_ce_n) begin
                if (t_k == 0) begin
                    t_adr = sr_adr; t_be = sr_be_n; t_dout = sr_dout;
                end else if (sr_adr !== t_adr || sr_be_n !== t_be) begin
                    t_stable = 1'b0;
                end
                if (!sr_we_n && t_k < 8) t_we[t_k] = 1'b1;
                if (!sr_oe_n) t_oe++;
                if (sr_dout_en) t_en++;
                t_k++;
            end
            if (cpu_ack) begin
                t_acked = 1'b1; t_lat = n; t_rd = cpu_rdata;
            end
        end
        cpu_req = 1'b0;
    endtask

    // Transaction-level reference state for the random phase
    logic [31:0] refmem [64];
    logic        pend [3];
    logic        rwr [3];
    logic        rbyt [3];
    int          radr [3];
    int          rlane [3];
    logic [31:0] rwd [3];
    int          ack_at [3];
    logic        ewr [3];
    logic [31:0] erd [3];
    int          free_at, acc_start, run, g;
    int          dut_cnt [3];
    int          mdl_cnt [3];
    int          streak, max_streak, tv, tc, nack;

    initial begin
        rst = 1'b1;
        vid_req = 0; vid_adr = '0; cpu_req = 0; cpu_wr = 0; cpu_byte = 0; cpu_adr = '0; cpu_wdata = '0;
        dma_req = 0; dma_wr = 0; dma_adr = '0; dma_wdata = '0;

        vt[0]  = '{1'b1, 1'b0, 20'h00010, 32'hDEADBEEF, 18'd4, 4'h0, 32'hDEADBEEF};
        vt[1]  = '{1'b0, 1'b0, 20'h00010, 32'h0,        18'd4, 4'h0, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 1'b0, 20'h00014, 32'h11223344, 18'd5, 4'h0, 32'h11223344};
        vt[3]  = '{1'b0, 1'b1, 20'h00014, 32'h0,        18'd5, 4'hE, 32'h00000044};
        vt[4]  = '{1'b0, 1'b1, 20'h00015, 32'h0,        18'd5, 4'hD, 32'h00000033};
        vt[5]  = '{1'b0, 1'b1, 20'h00016, 32'h0,        18'd5, 4'hB, 32'h00000022};
        vt[6]  = '{1'b0, 1'b1, 20'h00017, 32'h0,        18'd5, 4'h7, 32'h00000011};
        vt[7]  = '{1'b1, 1'b1, 20'h00007, 32'h000000A5, 18'd1, 4'h7, 32'hA5A5A5A5};
        vt[8]  = '{1'b0, 1'b0, 20'h00004, 32'h0,        18'd1, 4'h0, 32'hA5010101};
        vt[9]  = '{1'b1, 1'b1, 20'h00019, 32'hFFFFFF5A, 18'd6, 4'hD, 32'h5A5A5A5A};
        vt[10] = '{1'b0, 1'b0, 20'h00018, 32'h0,        18'd6, 4'h0, 32'h06065A06};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_strobes", 32'({vid_ack, cpu_ack, dma_ack, sr_ce_n, sr_oe_n, sr_we_n, sr_be_n, sr_dout_en}),
            32'b000_111_1111_0);
        chk("reset_vid_rdata", vid_rdata, 32'h0);
        chk("reset_cpu_rdata", cpu_rdata, 32'h0);
        chk("reset_dma_rdata", dma_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed CPU vectors
        for (int i = 0; i < 11; i++) begin
            cpu_op(vt[i].wr, vt[i].byt, vt[i].adr, vt[i].wd);
            chk($sformatf("vec%0d acked", i), 32'(t_acked), 32'd1);
            chk($sformatf("vec%0d ack_latency", i), 32'(t_lat), 32'(ACC + 1));
            chk($sformatf("vec%0d sr_adr", i), 32'(t_adr), 32'(vt[i].eadr));
            chk($sformatf("vec%0d sr_be_n", i), 32'(t_be), 32'(vt[i].ebe));
            chk($sformatf("vec%0d adr_be_stable", i), 32'(t_stable), 32'd1);
            chk($sformatf("vec%0d we_pattern", i), 32'(t_we), vt[i].wr ? 32'b010 : 32'b000);
            chk($sformatf("vec%0d oe_cycles", i), 32'(t_oe), vt[i].wr ? 32'd0 : 32'(ACC));
            chk($sformatf("vec%0d dout_en_cycles", i), 32'(t_en), vt[i].wr ? 32'(ACC) : 32'd0);
            if (vt[i].wr) chk($sformatf("vec%0d sr_dout", i), t_dout, vt[i].edata);
            else          chk($sformatf("vec%0d cpu_rdata", i), t_rd, vt[i].edata);
            @(negedge clk);
        end

        // Reset in the middle of a write (at k=1)
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_byte = 1'b0; cpu_adr = 20'h00080; cpu_wdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        chk("midwr_we_low_k1", 32'(sr_we_n), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midwr_after_reset", 32'({sr_we_n, sr_ce_n, sr_dout_en}), 32'b110);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        nack = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_ack) nack++;
        end
        chk("midwr_no_cpu_ack", 32'(nack), 32'd0);

        // VID and CPU raised together
        vid_req = 1'b1; vid_adr = 18'd3;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_byte = 1'b0; cpu_adr = 20'h00008;
        tv = -1; tc = -1;
        for (int n = 1; n <= 30 && (tv < 0 || tc < 0); n++) begin
            @(negedge clk);
            if (vid_ack) begin tv = n; vid_req = 1'b0; chk("vidcpu vid_rdata", vid_rdata, 32'h03030303); end
            if (cpu_ack) begin tc = n; cpu_req = 1'b0; chk("vidcpu cpu_rdata", cpu_rdata, 32'h02020202); end
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        chk("vidcpu vid_ack_time", 32'(tv), 32'(ACC + 1));
        chk("vidcpu cpu_after_vid", 32'(tc - tv), 32'(ACC + 1));

        // Randomized traffic against the reference model
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) refmem[i] = 32'(i) * 32'h01010101;
        for (int p = 0; p < 3; p++) begin
            pend[p] = 0; rwr[p] = 0; rbyt[p] = 0; radr[p] = 0; rlane[p] = 0; rwd[p] = '0;
            ack_at[p] = -1; ewr[p] = 0; erd[p] = '0; dut_cnt[p] = 0; mdl_cnt[p] = 0;
        end
        free_at = 0; acc_start = 0; run = 0; streak = 0; max_streak = 0;

        for (int c = 0; c < NC; c++) begin
            logic [2:0]  dack;
            logic [31:0] drd [3];
            logic        ok [3];
            @(negedge clk);
            dack = {dma_ack, cpu_ack, vid_ack};
            drd[0] = vid_rdata; drd[1] = cpu_rdata; drd[2] = dma_rdata;
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("rnd c%0d ack%0d", c, p), 32'(dack[p]), 32'(ack_at[p] == c));
                if (ack_at[p] == c && !ewr[p]) chk($sformatf("rnd c%0d rdata%0d", c, p), drd[p], erd[p]);
                if (c < HOLD && ack_at[p] == c) mdl_cnt[p]++;
                if (c < HOLD && dack[p]) dut_cnt[p]++;
            end
            if (c < HOLD) begin
                if (dack[1]) begin streak++; if (streak > max_streak) max_streak = streak; end
                if (dack[2]) streak = 0;
            end
            chk($sformatf("rnd c%0d sr_ce_n", c), 32'(sr_ce_n), 32'(!(c >= acc_start && c < free_at)));

            // Requesters: hold inputs until ack; first phase re-requests at once.
            for (int p = 0; p < 3; p++) begin
                if (ack_at[p] == c) pend[p] = 1'b0;
                if (!pend[p] && (c < HOLD || $urandom_range(0, 2) == 0)) begin
                    pend[p]  = 1'b1;
                    rwr[p]   = (p == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                    rbyt[p]  = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    radr[p]  = $urandom_range(0, 63);
                    rlane[p] = (p == 1) ? $urandom_range(0, 3) : 0;
                    rwd[p]   = $urandom;
                end
            end
            vid_req = pend[0]; vid_adr = AW'(radr[0]);
            cpu_req = pend[1]; cpu_wr = rwr[1]; cpu_byte = rbyt[1];
            cpu_adr = {AW'(radr[1]), 2'(rlane[1])}; cpu_wdata = rwd[1];
            dma_req = pend[2]; dma_wr = rwr[2]; dma_adr = AW'(radr[2]); dma_wdata = rwd[2];

            g = -1;
            if (c >= free_at) begin
                for (int p = 0; p < 3; p++) ok[p] = pend[p] && (ack_at[p] != c);
                if (ok[0])                    g = 0;
                else if (ok[2] && run == RMAX) g = 2;
                else if (ok[1])               g = 1;
                else if (ok[2])               g = 2;
                if (g >= 0) begin
                    acc_start = c + 1;
                    free_at   = c + 1 + ACC;
                    ack_at[g] = c + 1 + ACC;
                    ewr[g]    = rwr[g];
                    if (rwr[g]) begin
                        if (rbyt[g]) refmem[radr[g]][8*rlane[g] +: 8] = rwd[g][7:0];
                        else         refmem[radr[g]] = rwd[g];
                    end else begin
                        erd[g] = rbyt[g] ? {24'h0, refmem[radr[g]][8*rlane[g] +: 8]} : refmem[radr[g]];
                    end
                end
            end
            if (!pend[2])                  run = 0;
            else if (g == 2)               run = 0;
            else if (g == 1 && run < RMAX) run++;
        end
        for (int p = 0; p < 3; p++)
            chk($sformatf("hold ack_count%0d", p), 32'(dut_cnt[p]), 32'(mdl_cnt[p]));
        chk("hold dma_not_starved", 32'(dut_cnt[2] > 0), 32'd1);
        chk("hold cpu_run_length", 32'(max_streak), 32'(RMAX));

        vid_req = 0; cpu_req = 0; dma_req = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
